// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with registered back-pressure.
// Optional stall counter output enabled by PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             in_fire, out_fire;

   // Handshake outputs decode straight from the state flop, so nothing downstream reaches in_ready.
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = (state_q != TWO);
   assign out_data  = m_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  m_d     = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  m_d = in_data;
               end else if (in_fire) begin
                  s_d     = in_data;
                  state_d = TWO;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  m_d     = s_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         m_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         s_q     <= s_d;
      end
   end

`ifdef PIPE_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random
// traffic compared against a two-deep queue model.
module tb_pipe_skid_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int unsigned n_checks;
   int unsigned n_errors;

   logic [15:0] mq[$];
   int unsigned m_stall;

   pipe_skid_reg #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() != 0});
      check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (mq.size() != 0)
         check({tag, ".out_data"}, {16'd0, out_data}, {16'd0, mq[0]});
`ifdef PIPE_SKID_STALL_CNT_EN
      check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, m_stall);
`endif
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then compare.
   task automatic step(input string tag, input logic iv, input logic [15:0] d,
                       input logic ordy, input logic fl);
      bit ifire, ofire;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      ifire = iv && (mq.size() < 2);
      ofire = ordy && (mq.size() != 0);
      if ((mq.size() != 0) && !ordy && (m_stall < 32'hFFFF)) m_stall++;
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         if (ofire) void'(mq.pop_front());
         if (ifire) mq.push_back(d);
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      rst       = 1'b0;
      mq.delete();
      m_stall = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);
      check("rst.out_data", {16'd0, out_data}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      do_reset();

      // Streaming with out_ready held high.
      for (int i = 1; i <= 8; i++) step("stream", 1'b1, 16'(i), 1'b1, 1'b0);
      step("stream_drain", 1'b0, '0, 1'b1, 1'b0);

      // Stall absorb: two accepted, third held upstream.
      step("stall0", 1'b1, 16'h0010, 1'b0, 1'b0);
      step("stall1", 1'b1, 16'h0011, 1'b0, 1'b0);
      check("stall.in_ready_low", {31'd0, in_ready}, 32'd0);
      step("stall2", 1'b1, 16'h0012, 1'b0, 1'b0);
      check("stall.head", {16'd0, out_data}, 32'h0010);
      step("drain0", 1'b1, 16'h0012, 1'b1, 1'b0);
      check("drain.head", {16'd0, out_data}, 32'h0011);
      step("drain1", 1'b1, 16'h0012, 1'b1, 1'b0);
      check("drain.tail", {16'd0, out_data}, 32'h0012);
      step("drain2", 1'b0, '0, 1'b1, 1'b0);

      // Flush in TWO while presenting a word that must vanish.
      step("fl_a", 1'b1, 16'h0030, 1'b0, 1'b0);
      step("fl_b", 1'b1, 16'h0031, 1'b0, 1'b0);
      step("flush", 1'b1, 16'hDEAD, 1'b0, 1'b1);
      check("flush.out_valid", {31'd0, out_valid}, 32'd0);
      check("flush.in_ready", {31'd0, in_ready}, 32'd1);
      step("post_flush", 1'b0, '0, 1'b1, 1'b0);

      // Simultaneous fire in ONE.
      step("sim0", 1'b1, 16'h0020, 1'b0, 1'b0);
      step("sim1", 1'b1, 16'h0021, 1'b1, 1'b0);
      check("sim.data", {16'd0, out_data}, 32'h0021);
      check("sim.in_ready", {31'd0, in_ready}, 32'd1);
      step("sim2", 1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset between edges while holding two words.
      step("rm_a", 1'b1, 16'hAAAA, 1'b0, 1'b0);
      step("rm_b", 1'b1, 16'hBBBB, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst.out_valid", {31'd0, out_valid}, 32'd0);
      check("arst.in_ready", {31'd0, in_ready}, 32'd1);
      check("arst.out_data", {16'd0, out_data}, 32'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
      check("arst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      mq.delete();
      m_stall = 0;
      @(negedge clk);
      rst = 1'b1;
      step("first_after_rst", 1'b1, 16'h0040, 1'b1, 1'b0);

      // Random traffic against the queue model.
      for (int i = 0; i < 3000; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      end

`ifdef PIPE_SKID_STALL_CNT_EN
      // Long stall saturates the counter; flush must not clear it.
      step("sat_load", 1'b1, 16'h0050, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) step("sat", 1'b0, '0, 1'b0, 1'b0);
      check("sat.stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);
      step("sat_flush", 1'b0, '0, 1'b0, 1'b1);
      check("sat.after_flush", {16'd0, stall_cnt}, 32'hFFFF);
      do_reset();
      check("sat.after_rst", {16'd0, stall_cnt}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Two-entry valid/ready pipeline register placed between CPU pipeline stages, directly upstream of the per-bit write-enabled flip-flop banks that hold stage state. It converts a downstream stall into a registered back-pressure signal, so no combinational path runs from `out_ready` to `in_ready`. It generates the capture enables for its own main and skid data registers.

## Interface
- `WIDTH`, 16: payload width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `flush`  input  1  synchronous pipeline flush; highest priority after reset.
- `in_valid`  input  1  upstream presents `in_data`.
- `in_ready`  output  1  block can accept; registered.
- `in_data`  input  WIDTH  upstream payload.
- `out_valid`  output  1  `out_data` is valid; registered.
- `out_ready`  input  1  downstream accepts this cycle.
- `out_data`  output  WIDTH  payload; driven directly from the main register.
- `stall_cnt`  output  16  stall counter; present only with `PIPE_SKID_STALL_CNT_EN`.

## Operation
- Storage: main register (M), skid register (S), 2-bit state: EMPTY, ONE (M valid), TWO (M and S valid).
- Handshakes: input fire = `in_valid & in_ready`; output fire = `out_valid & out_ready`.
- Decoded outputs: `out_valid` = (state != EMPTY), `in_ready` = (state != TWO), `out_data` = M.
- EMPTY: input fire -> M <= `in_data`, go to ONE. Otherwise stay.
- ONE, input and output fire together: M <= `in_data`, stay ONE.
- ONE, input fire only: S <= `in_data`, go to TWO.
- ONE, output fire only: go to EMPTY. Neither fire: hold.
- TWO: `in_ready`=0. Output fire: M <= S, go to ONE. Otherwise hold.
- Ordering: strictly FIFO. A word is never duplicated or dropped except by flush.
- Flush:
  - State goes to EMPTY on the next edge.
  - Any input fire in the flush cycle is discarded.
  - M and S contents are left unchanged but are invalid.
- Data register updates: M and S update only on the enables listed above. They hold otherwise, with no spurious writes.
- Reset (`rst`=0, any time, including mid-transfer):
  - State = EMPTY; M = 0; S = 0.
  - `out_valid`=0, `in_ready`=1, `out_data`=0, `stall_cnt`=0.
- Reset release: synchronous to `clk` (externally synchronised). The first capture is allowed on the first edge after deassertion.

## Timing
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- Back-pressure:
  - `in_ready` falls one edge after the stall begins; the skid absorbs the one in-flight word.
  - `in_ready` rises on the edge after the first output fire in TWO.
- `out_valid` and `out_data` are stable while `out_valid & !out_ready`.
- No combinational path from any input to `in_ready`, `out_valid` or `out_data`.

## Configuration
- `PIPE_SKID_STALL_CNT_EN` defined:
  - Adds the `stall_cnt` output, a 16-bit counter.
  - Increments each cycle where `out_valid & !out_ready`.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared by reset only; flush does not clear it.
- `PIPE_SKID_STALL_CNT_EN` not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-transfer: state TWO holding 16'hAAAA/16'hBBBB, pull `rst` low asynchronously between edges -> immediately `out_valid`=0, `in_ready`=1, `out_data`=16'h0000.
- Streaming: `out_ready`=1, feed 16'h0001..16'h0008 back-to-back -> same sequence on `out_data`, one per cycle, first value one cycle after acceptance, `in_ready` never low.
- Stall absorb: feed 16'h0010, 16'h0011, 16'h0012 with `out_ready`=0 -> first two accepted, `in_ready`=0 after the second edge, 16'h0012 held upstream. Then `out_ready`=1 -> outputs 16'h0010, 16'h0011, 16'h0012 in order.
- Flush in TWO: flush with `in_valid`=1 carrying 16'hDEAD -> next cycle `out_valid`=0, `in_ready`=1; 16'hDEAD never appears at the output.
- Simultaneous in/out fire in ONE: M=16'h0020, present 16'h0021 with `out_ready`=1 -> 16'h0020 consumed, 16'h0021 on `out_data` next cycle, state stays ONE.
- With `PIPE_SKID_STALL_CNT_EN` defined: hold `out_valid`=1, `out_ready`=0 for 70000 cycles -> `stall_cnt`=16'hFFFF, no wrap. After reset -> `stall_cnt`=0.
